// File: rtl/io_pipe_responder.sv
// Far-end pipe stage responder: runs one requested stage for STAGE_CYCLES edges, then pulses its ok.
// Optional sticky multi-request error check is enabled by defining IO_PIPE_REQ_CHECK_EN.
module io_pipe_responder #(
  parameter int STAGE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic wd_rst,
  input  logic idle_i,
  input  logic activate_i,
  input  logic hibernate_i,
  input  logic sleep_i,
  input  logic charge_i,
  input  logic stream_eeg_i,
  input  logic process_eeg_i,
  input  logic interpret_eeg_i,
  input  logic build_ble_cmd_i,
  input  logic publish_ble_cmd_i,
  output logic afe_ok_o,
  output logic a2d_ok_o,
  output logic dsp_ok_o,
  output logic blem_ok_o,
  output logic ble_sent_o,
  output logic busy_o,
  output logic halted_o,
  output logic err_o
);

  typedef enum logic [2:0] {
    IDLE, STREAM, PROCESS, INTERPRET, BUILD, PUBLISH, HALT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STAGE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       ok_q, ok_d;
  logic [5:0]       req, hist_q, rise;
  logic             primed_q;
  logic             halt_req;
  logic             unused_activate;

  assign req      = {publish_ble_cmd_i, build_ble_cmd_i, interpret_eeg_i,
                     process_eeg_i, stream_eeg_i, idle_i};
  // The first edge after reset only primes the history, so a level held across reset never starts a stage.
  assign rise     = primed_q ? (req & ~hist_q) : 6'b0;
  assign halt_req = hibernate_i | sleep_i | charge_i;
  assign unused_activate = activate_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ok_d    = 5'b0;
    if (halt_req) begin
      state_d = HALT;
      cnt_d   = '0;
    end else if (state_q == HALT) begin
      state_d = IDLE;
    end else if (rise[0]) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      cnt_d = CNT_LOAD;
      if      (rise[1]) state_d = STREAM;
      else if (rise[2]) state_d = PROCESS;
      else if (rise[3]) state_d = INTERPRET;
      else if (rise[4]) state_d = BUILD;
      else if (rise[5]) state_d = PUBLISH;
      else              cnt_d   = '0;
    end else if (cnt_q == '0) begin
      state_d = IDLE;
      case (state_q)
        STREAM:    ok_d[0] = 1'b1;
        PROCESS:   ok_d[1] = 1'b1;
        INTERPRET: ok_d[2] = 1'b1;
        BUILD:     ok_d[3] = 1'b1;
        PUBLISH:   ok_d[4] = 1'b1;
        default:   ok_d    = 5'b0;
      endcase
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wd_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ok_q     <= 5'b0;
      hist_q   <= 6'b0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ok_q     <= ok_d;
      hist_q   <= req;
      primed_q <= 1'b1;
    end
  end

  assign afe_ok_o   = ok_q[0];
  assign a2d_ok_o   = ok_q[1];
  assign dsp_ok_o   = ok_q[2];
  assign blem_ok_o  = ok_q[3];
  assign ble_sent_o = ok_q[4];
  assign busy_o     = (state_q != IDLE) && (state_q != HALT);
  assign halted_o   = (state_q == HALT);

`ifdef IO_PIPE_REQ_CHECK_EN
  logic [9:0] all_req;
  logic       err_q;

  assign all_req = {publish_ble_cmd_i, build_ble_cmd_i, interpret_eeg_i, process_eeg_i,
                    stream_eeg_i, charge_i, sleep_i, hibernate_i, activate_i, idle_i};

  always_ff @(posedge clk) begin
    if (wd_rst)                    err_q <= 1'b0;
    else if ($countones(all_req) > 1) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
